// File: rtl/fcal_pkg.sv
// Shared types and constants for the DCO frequency-calibration loop:
// controller states, measurement step phases, code widths and reset codes.
package fcal_pkg;

  localparam int C_W = 6;
  localparam int F_W = 7;

  localparam logic [C_W-1:0] C_RST = 6'd32;
  localparam logic [F_W-1:0] F_RST = 7'd64;
  localparam logic [F_W-1:0] F_MAX = 7'd127;

  // MSB index of each code: first trial bit of its binary search
  localparam logic [2:0] C_MSB = 3'd5;
  localparam logic [2:0] F_MSB = 3'd6;

  typedef enum logic [2:0] {
    IDLE,
    C_SAR,
    F_SAR,
    TRACK,
    LOCKED
  } fcal_state_e;

  typedef enum logic [1:0] {
    PH_SETTLE,
    PH_START_LATCH,
    PH_WINDOW,
    PH_DECIDE
  } fcal_phase_e;

  // One-hot mask selecting the trial bit of a code
  function automatic logic [6:0] bit_mask(input logic [2:0] idx);
    return 7'd1 << idx;
  endfunction

endpackage

// File: rtl/fcal_win_meas.sv
// Repeating measurement step: SETTLE discarded cycles, start-count latch,
// a 2**WIN_LOG2 cycle window, then one decide cycle carrying the result.
module fcal_win_meas
  import fcal_pkg::*;
#(
  parameter int CW       = 16,
  parameter int WIN_LOG2 = 5,
  parameter int SETTLE   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          clr,
  input  logic [CW-1:0] dco_cnt,
  output logic [CW-1:0] meas,
  output logic          meas_valid,
  output logic [1:0]    phase_dbg
);

  localparam int WIN   = 1 << WIN_LOG2;
  localparam int CNT_W = $clog2(((WIN > SETTLE) ? WIN : SETTLE) + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WIN - 1);

  fcal_phase_e      phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]    start_q, start_d;
  logic [CW-1:0]    meas_q, meas_d;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    meas_d  = meas_q;
    case (phase_q)
      PH_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          phase_d = PH_START_LATCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PH_START_LATCH: begin
        start_d = dco_cnt;
        phase_d = PH_WINDOW;
        cnt_d   = '0;
      end
      PH_WINDOW: begin
        if (cnt_q == WIN_LAST) begin
          // Unsigned subtraction is modulo 2**CW, so counter wrap is harmless
          meas_d  = dco_cnt - start_q;
          phase_d = PH_DECIDE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PH_DECIDE: begin
        phase_d = PH_SETTLE;
        cnt_d   = '0;
      end
      default: begin
        phase_d = PH_SETTLE;
        cnt_d   = '0;
      end
    endcase
    // Idle or a freshly applied code: hold at the start of the settle phase
    if (!run || clr) begin
      phase_d = PH_SETTLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_SETTLE;
      cnt_q   <= '0;
      start_q <= '0;
      meas_q  <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      meas_q  <= meas_d;
    end
  end

  // meas_valid is a single-cycle pulse with no backpressure; the consumer
  // must act on it in that cycle. meas holds until the next window ends.
  assign meas_valid = (phase_q == PH_DECIDE);
  assign meas       = meas_q;
  assign phase_dbg  = phase_q;

endmodule

// File: rtl/dco_freq_cal.sv
// DCO frequency calibration: binary search of coarse then fine code against
// FCW << WIN_LOG2 DCO edges per window. FCAL_TRACK_EN adds +/-1 fine tracking.
module dco_freq_cal
  import fcal_pkg::*;
#(
  parameter int CW       = 16,
  parameter int WIN_LOG2 = 5,
  parameter int SETTLE   = 4,
  parameter int DBAND    = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [7:0]    FCW,
  input  logic [CW-1:0] DCO_CNT,
  output logic [5:0]    DCTRL_C,
  output logic [6:0]    DCTRL_F,
  output logic          BUSY,
  output logic          LOCK,
  output logic          FINE_SAT,
  output logic [2:0]    dbg_state,
  output logic [1:0]    dbg_phase
);

  fcal_state_e    state_q, state_d;
  logic [C_W-1:0] c_q, c_d;
  logic [F_W-1:0] f_q, f_d;
  logic [2:0]     idx_q, idx_d;
  logic [CW-1:0]  target_q, target_d;
  logic           sat_q, sat_d;

  logic           busy;
  logic           start_acc;
  logic           meas_run;
  logic [CW-1:0]  meas;
  logic           meas_valid;
  logic [6:0]     mask;
  logic           too_fast;
  logic [CW-1:0]  track_hi, track_lo;

`ifdef FCAL_TRACK_EN
  localparam fcal_state_e LOCK_STATE = TRACK;
  assign FINE_SAT = sat_q;
`else
  localparam fcal_state_e LOCK_STATE = LOCKED;
  assign FINE_SAT = 1'b0;
`endif

  assign busy      = (state_q == C_SAR) || (state_q == F_SAR);
  assign start_acc = START && !busy;
  assign meas_run  = (state_q == C_SAR) || (state_q == F_SAR) || (state_q == TRACK);

  fcal_win_meas #(
    .CW       (CW),
    .WIN_LOG2 (WIN_LOG2),
    .SETTLE   (SETTLE)
  ) u_meas (
    .clk        (CLK),
    .rst        (RST),
    .run        (meas_run),
    .clr        (start_acc),
    .dco_cnt    (DCO_CNT),
    .meas       (meas),
    .meas_valid (meas_valid),
    .phase_dbg  (dbg_phase)
  );

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    f_d      = f_q;
    idx_d    = idx_q;
    target_d = target_q;
    sat_d    = sat_q;
    mask     = bit_mask(idx_q);
    too_fast = (meas > target_q);
    track_hi = target_q + CW'(DBAND);
    track_lo = target_q - CW'(DBAND);

    case (state_q)
      C_SAR: begin
        if (meas_valid) begin
          if (too_fast) c_d = c_q & ~mask[5:0];
          if (idx_q == 3'd0) begin
            state_d = F_SAR;
            f_d     = F_RST;
            idx_d   = F_MSB;
          end else begin
            c_d   = c_d | mask[6:1];
            idx_d = idx_q - 3'd1;
          end
        end
      end
      F_SAR: begin
        if (meas_valid) begin
          if (too_fast) f_d = f_q & ~mask;
          if (idx_q == 3'd0) begin
            state_d = LOCK_STATE;
          end else begin
            f_d   = f_d | (mask >> 1);
            idx_d = idx_q - 3'd1;
          end
        end
      end
      TRACK: begin
        // Saturation flag marks a wanted step that the code range cannot take
        if (meas_valid) begin
          if (meas > track_hi) begin
            if (f_q == '0) begin
              sat_d = 1'b1;
            end else begin
              f_d   = f_q - 1'b1;
              sat_d = 1'b0;
            end
          end else if (meas < track_lo) begin
            if (f_q == F_MAX) begin
              sat_d = 1'b1;
            end else begin
              f_d   = f_q + 1'b1;
              sat_d = 1'b0;
            end
          end else begin
            sat_d = 1'b0;
          end
        end
      end
      IDLE, LOCKED: ;
      default: state_d = IDLE;
    endcase

    if (start_acc) begin
      state_d  = C_SAR;
      c_d      = C_RST;
      f_d      = F_RST;
      idx_d    = C_MSB;
      target_d = CW'(FCW) << WIN_LOG2;
      sat_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      c_q      <= C_RST;
      f_q      <= F_RST;
      idx_q    <= C_MSB;
      target_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      f_q      <= f_d;
      idx_q    <= idx_d;
      target_q <= target_d;
      sat_q    <= sat_d;
    end
  end

  assign DCTRL_C   = c_q;
  assign DCTRL_F   = f_q;
  assign BUSY      = busy;
  assign LOCK      = (state_q == TRACK) || (state_q == LOCKED);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dco_freq_cal.sv
// Bench for dco_freq_cal: closed loop with an integer DCO model, a step-level
// reference model checked every cycle, and directed scenario checks.
module tb_dco_freq_cal;

  localparam int CW       = 16;
  localparam int WIN_LOG2 = 5;
  localparam int SETTLE   = 4;
  localparam int DBAND    = 2;
  localparam int STEP     = SETTLE + (1 << WIN_LOG2) + 2;
  localparam int LOCK_LAT = 13 * STEP;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic [7:0]    FCW;
  logic [CW-1:0] DCO_CNT;
  logic [5:0]    DCTRL_C;
  logic [6:0]    DCTRL_F;
  logic          BUSY;
  logic          LOCK;
  logic          FINE_SAT;
  logic [2:0]    dbg_state;
  logic [1:0]    dbg_phase;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  longint acc;
  int     offset_mhz;

  logic [12:0] exp_q[$];

  dco_freq_cal #(
    .CW(CW), .WIN_LOG2(WIN_LOG2), .SETTLE(SETTLE), .DBAND(DBAND)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .FCW(FCW), .DCO_CNT(DCO_CNT),
    .DCTRL_C(DCTRL_C), .DCTRL_F(DCTRL_F), .BUSY(BUSY), .LOCK(LOCK),
    .FINE_SAT(FINE_SAT), .dbg_state(dbg_state), .dbg_phase(dbg_phase)
  );

  // Clock and time limit
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  // DCO plant in MHz; one CLK is 1/40 us so edges accumulate in 1/40 units
  always @(negedge CLK) begin
    acc = acc + 2271 + 50 * int'(DCTRL_C) + 2 * int'(DCTRL_F) + offset_mhz;
    DCO_CNT = CW'(acc / 40);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference model: step-level timeline counted from the accepted START edge
  int          m_c, m_f, m_cyc, m_step;
  bit          m_busy, m_lock, m_sat, m_run;
  logic [15:0] m_s, m_meas, m_target;

  always @(posedge CLK) begin
    if (RST) begin
      m_c = 32; m_f = 64; m_busy = 0; m_lock = 0; m_sat = 0; m_run = 0; m_cyc = 0;
    end else if (START && !m_busy) begin
      m_target = 16'(int'(FCW) * (1 << WIN_LOG2));
      m_c = 32; m_f = 64; m_busy = 1; m_lock = 0; m_sat = 0; m_run = 1; m_cyc = 0;
    end else if (m_run) begin
      m_cyc++;
      if (m_cyc % STEP == SETTLE + 1) m_s = DCO_CNT;
      if (m_cyc % STEP == STEP - 1) m_meas = DCO_CNT - m_s;
      if (m_cyc % STEP == 0) begin
        m_step = m_cyc / STEP - 1;
        if (m_step < 6) begin
          if (m_meas > m_target) m_c -= (1 << (5 - m_step));
          if (m_step < 5) m_c += (1 << (4 - m_step));
        end else if (m_step < 13) begin
          if (m_meas > m_target) m_f -= (1 << (12 - m_step));
          if (m_step < 12) m_f += (1 << (11 - m_step));
          if (m_step == 12) begin
            m_busy = 0;
            m_lock = 1;
            exp_q.push_back({6'(m_c), 7'(m_f)});
`ifndef FCAL_TRACK_EN
            m_run = 0;
`endif
          end
        end else begin
          if (int'(m_meas) > int'(m_target) + DBAND) begin
            if (m_f == 0) m_sat = 1;
            else begin m_f--; m_sat = 0; end
          end else if (int'(m_meas) < int'(m_target) - DBAND) begin
            if (m_f == 127) m_sat = 1;
            else begin m_f++; m_sat = 0; end
          end else begin
            m_sat = 0;
          end
        end
      end
    end
  end

  // Compare process: every cycle once reset has been applied
  always @(negedge CLK) begin
    if (chk_en) begin
      check("dctrl_c", 32'(DCTRL_C), 32'(m_c));
      check("dctrl_f", 32'(DCTRL_F), 32'(m_f));
      check("busy", 32'(BUSY), 32'(m_busy));
      check("lock", 32'(LOCK), 32'(m_lock));
      check("fine_sat", 32'(FINE_SAT), 32'(m_sat));
    end
  end

  // Driver tasks
  task automatic pulse_start(input logic [7:0] fcw);
    FCW = fcw;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_lock(output int lat);
    lat = 0;
    while (LOCK !== 1'b1 && lat < 2000) begin
      @(negedge CLK);
      lat++;
    end
    if (LOCK !== 1'b1) begin
      n_checks++;
      n_err++;
      $display("FAIL lock_wait: got LOCK=%0b expected 1 within 2000 cycles", LOCK);
    end
  endtask

  task automatic sb_pop(input string name, output logic [12:0] codes);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_err++;
      codes = '0;
      $display("FAIL %s: got no model lock expected one", name);
    end else begin
      codes = exp_q.pop_front();
      check(name, 32'({DCTRL_C, DCTRL_F}), 32'(codes));
    end
  endtask

  int          lat, lat2, diff;
  logic [15:0] s_cnt;
  logic [12:0] codes;

  initial begin
    RST = 1'b1; START = 1'b0; FCW = '0; offset_mhz = 0; acc = 0; DCO_CNT = '0;
    repeat (3) @(negedge CLK);
    chk_en = 1'b1;
    check("rst_c", 32'(DCTRL_C), 32);
    check("rst_f", 32'(DCTRL_F), 64);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_lock", 32'(LOCK), 0);
    check("rst_sat", 32'(FINE_SAT), 0);
    RST = 1'b0;
    @(negedge CLK);

    // FCW=100: 4.0 GHz sits at C=32, F=64.5
    pulse_start(8'd100);
    check("busy_after_start", 32'(BUSY), 1);
    wait_lock(lat);
    check("lock_latency", 32'(lat), LOCK_LAT);
    check("c_fcw100", 32'(DCTRL_C), 32);
    check_range("f_fcw100", int'(DCTRL_F), 64, 65);
    check("busy_after_lock", 32'(BUSY), 0);
    sb_pop("codes_fcw100", codes);

    // Restart from lock: LOCK must fall on the accepting edge
    pulse_start(8'd80);
    check("lock_drop", 32'(LOCK), 0);
    check("busy_restart", 32'(BUSY), 1);
    wait_lock(lat);
    check("c_fcw80", 32'(DCTRL_C), 16);
    check_range("f_fcw80", int'(DCTRL_F), 64, 65);
    sb_pop("codes_fcw80", codes);

    // FCW=120: 4.8 GHz, residual within 3 counts per window
    pulse_start(8'd120);
    wait_lock(lat);
    check("c_fcw120", 32'(DCTRL_C), 48);
    check_range("f_fcw120", int'(DCTRL_F), 64, 65);
    sb_pop("codes_fcw120", codes);
    #1 s_cnt = DCO_CNT;
    repeat (32) @(negedge CLK);
    #1 diff = int'(16'(DCO_CNT - s_cnt));
    check_range("meas_err120", diff, 3840 - 3, 3840 + 3);

    // Preload so the counter wraps inside the first measurement window
    acc = longint'(16'hF900) * 40;
    pulse_start(8'd100);
    wait_lock(lat);
    check("c_wrap", 32'(DCTRL_C), 32);
    check_range("f_wrap", int'(DCTRL_F), 64, 65);
    sb_pop("codes_wrap", codes);

    // Second START while busy must be ignored, FCW=80 must not be picked up
    pulse_start(8'd100);
    repeat (100) @(negedge CLK);
    pulse_start(8'd80);
    check("busy_kept", 32'(BUSY), 1);
    wait_lock(lat2);
    check("lock_latency_ignored", 32'(101 + lat2), LOCK_LAT);
    check("c_ignored", 32'(DCTRL_C), 32);
    sb_pop("codes_ignored", codes);

    // Reset in the middle of the fine search
    pulse_start(8'd100);
    repeat (6 * STEP + 50) @(negedge CLK);
    check("busy_in_fsar", 32'(BUSY), 1);
    RST = 1'b1;
    @(negedge CLK);
    check("abort_c", 32'(DCTRL_C), 32);
    check("abort_f", 32'(DCTRL_F), 64);
    check("abort_busy", 32'(BUSY), 0);
    check("abort_lock", 32'(LOCK), 0);
    RST = 1'b0;
    @(negedge CLK);

    // Frequency offset after lock
    pulse_start(8'd100);
    wait_lock(lat);
    sb_pop("codes_pre_offset", codes);
    #1 offset_mhz = 10;
`ifdef FCAL_TRACK_EN
    repeat (12 * STEP) @(negedge CLK);
    check_range("track_f_drop", int'(codes[6:0]) - int'(DCTRL_F), 4, 6);
    check("track_sat_clear", 32'(FINE_SAT), 0);
    check("track_lock_held", 32'(LOCK), 1);
    #1 offset_mhz = 300;
    repeat (80 * STEP) @(negedge CLK);
    check("track_f_floor", 32'(DCTRL_F), 0);
    check("track_sat_set", 32'(FINE_SAT), 1);
    check("track_c_frozen", 32'(DCTRL_C), 32'(codes[12:7]));
`else
    repeat (5 * STEP) @(negedge CLK);
    check("frozen_c", 32'(DCTRL_C), 32'(codes[12:7]));
    check("frozen_f", 32'(DCTRL_F), 32'(codes[6:0]));
    check("frozen_sat", 32'(FINE_SAT), 0);
    check("frozen_lock", 32'(LOCK), 1);
`endif

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
